// File: rtl/cus19_boot_loader_pkg.sv
// Shared cus19 definitions: loader state encoding and image-format constants.
package cus19_boot_loader_pkg;

    typedef enum logic [3:0] {
        HDR_HI,
        HDR_LO,
        B0,
        B1,
        B2,
        WRITE,
        CHK,
        DONE,
        ERR
    } loader_state_t;

    localparam int HDR_BYTES   = 2;
    localparam int INSTR_BYTES = 3;

    // States in which the loader is willing to take a byte from the link.
    function automatic logic accepts_byte(input loader_state_t s);
        return (s inside {HDR_HI, HDR_LO, B0, B1, B2, CHK});
    endfunction

endpackage

// File: rtl/cus19_boot_loader.sv
// Serial boot loader for the cus19 core: receives an image over a byte link,
// writes it into instruction memory, verifies an XOR checksum and releases
// the core from reset once the image is accepted.
module cus19_boot_loader
    import cus19_boot_loader_pkg::*;
#(
    parameter int PC_Width    = 11,
    parameter int Instr_Width = 19
) (
    input  logic                   cus19_clk_in,
    input  logic                   cus19_rst_in,
    input  logic [7:0]             rx_data_in,
    input  logic                   rx_valid_in,
    output logic                   rx_ready_out,
    output logic                   im_wr_en_out,
    output logic [PC_Width-1:0]    im_wr_addr_out,
    output logic [Instr_Width-1:0] im_wr_data_out,
    output logic                   cpu_rst_out,
    output logic                   load_done_out,
    output logic                   err_out
);

    localparam int          CNT_W = PC_Width + 1;
    localparam logic [16:0] MAX_N = 17'(1) << PC_Width;

    loader_state_t        state;
    loader_state_t        state_next;
    logic [7:0]           hdr_hi_q;
    logic [15:0]          n_q;
    logic [2:0]           b0_q;
    logic [7:0]           b1_q;
    logic [7:0]           xor_q;
    logic [PC_Width-1:0]  addr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 accept;
    logic [16:0]          n_hdr;
    logic [16:0]          written_next;

    // Ready is gated by reset so the link sees a stalled loader while held in reset.
    assign rx_ready_out  = cus19_rst_in && accepts_byte(state);
    assign accept        = rx_valid_in && rx_ready_out;
    assign n_hdr         = {1'b0, hdr_hi_q, rx_data_in};
    assign written_next  = 17'(cnt_q) + 17'd1;

    assign im_wr_en_out  = (state == WRITE);
    assign cpu_rst_out   = (state != DONE);
    assign load_done_out = (state == DONE);
    assign err_out       = (state == ERR);

    // State register.
    always_ff @(posedge cus19_clk_in or negedge cus19_rst_in) begin
        if (!cus19_rst_in) begin
            state <= HDR_HI;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; byte-consuming states advance only on a handshake.
    always_comb begin
        state_next = state;
        case (state)
            HDR_HI: if (accept) state_next = HDR_LO;
            HDR_LO: begin
                if (accept) begin
                    if (n_hdr == 17'd0 || n_hdr > MAX_N) begin
                        state_next = ERR;
                    end else begin
                        state_next = B0;
                    end
                end
            end
            B0:     if (accept) state_next = B1;
            B1:     if (accept) state_next = B2;
            B2:     if (accept) state_next = WRITE;
            WRITE:  state_next = (written_next < {1'b0, n_q}) ? B0 : CHK;
            CHK: begin
                if (accept) begin
                    state_next = (rx_data_in == xor_q) ? DONE : ERR;
                end
            end
            DONE:   state_next = DONE;
            ERR:    state_next = ERR;
            default: state_next = HDR_HI;
        endcase
    end

    // Datapath: header capture, instruction assembly, write port, counters and checksum.
    always_ff @(posedge cus19_clk_in or negedge cus19_rst_in) begin
        if (!cus19_rst_in) begin
            hdr_hi_q       <= '0;
            n_q            <= '0;
            b0_q           <= '0;
            b1_q           <= '0;
            xor_q          <= '0;
            addr_q         <= '0;
            cnt_q          <= '0;
            im_wr_addr_out <= '0;
            im_wr_data_out <= '0;
        end else begin
            if (accept && state != CHK) begin
                xor_q <= xor_q ^ rx_data_in;
            end
            case (state)
                HDR_HI: if (accept) hdr_hi_q <= rx_data_in;
                HDR_LO: if (accept) n_q <= {hdr_hi_q, rx_data_in};
                B0:     if (accept) b0_q <= rx_data_in[2:0];
                B1:     if (accept) b1_q <= rx_data_in;
                B2: begin
                    if (accept) begin
                        im_wr_data_out <= Instr_Width'({b0_q, b1_q, rx_data_in});
                        im_wr_addr_out <= addr_q;
                    end
                end
                WRITE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (addr_q != '1) begin
                        addr_q <= addr_q + PC_Width'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cus19_boot_loader.md
CUS19_BOOT_LOADER -- requirements
Module: cus19_boot_loader

Interface
REQ-001 Parameters SHALL be: PC_Width, default 11, instruction-memory address width; Instr_Width, default 19, instruction width.
REQ-002 Port cus19_clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port cus19_rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port rx_data_in, input, 8 bits: serial-link byte.
REQ-005 Port rx_valid_in, input, 1 bit: rx_data_in is valid.
REQ-006 Port rx_ready_out, output, 1 bit: the loader can accept a byte; a byte transfers on a rising edge where valid and ready are both high.
REQ-007 Port im_wr_en_out, output, 1 bit: instruction-memory write strobe.
REQ-008 Port im_wr_addr_out, output, PC_Width bits: instruction-memory write address.
REQ-009 Port im_wr_data_out, output, Instr_Width bits: instruction word to write.
REQ-010 Port cpu_rst_out, output, 1 bit: active-high reset to the cus19 core; high holds the core in reset.
REQ-011 Port load_done_out, output, 1 bit: image loaded and checksum passed.
REQ-012 Port err_out, output, 1 bit: image rejected.

Function
REQ-013 Image format SHALL be, in order: count high byte, count low byte (N, 16-bit, big-endian); N instructions of 3 bytes each, MSB first; one checksum byte.
REQ-014 Instruction assembly SHALL be {b0[2:0], b1, b2}; b0[7:3] is ignored.
REQ-015 States SHALL be HDR_HI, HDR_LO, B0, B1, B2, WRITE, CHK, DONE, ERR.
REQ-016 State transitions SHALL be:
- HDR_HI to HDR_LO, HDR_LO to B0, B0 to B1, B1 to B2, and B2 to WRITE, each on byte accept.
- WRITE to B0 if instructions written < N, else to CHK.
- CHK to DONE or ERR on byte accept.
REQ-017 In HDR_LO, if N == 0 or N > 2**PC_Width, the loader SHALL go to ERR instead of B0.
REQ-018 rx_ready_out SHALL be high only in HDR_HI, HDR_LO, B0, B1, B2 and CHK; it SHALL be low in WRITE, DONE and ERR.
REQ-019 In WRITE, im_wr_en_out SHALL be high for exactly one cycle, driving the assembled word and the current address.
REQ-020 The address SHALL start at 0 and increment after each write.
REQ-021 The last legal address SHALL be 2**PC_Width-1; the address counter SHALL never wrap within one image.
REQ-022 The instruction counter SHALL be PC_Width+1 bits wide so that N = 2048 is representable.
REQ-023 A running XOR SHALL be kept over every accepted byte except the checksum byte.
REQ-024 In CHK, a received byte equal to the running XOR SHALL lead to DONE; any other value SHALL lead to ERR.
REQ-025 Outside WRITE, im_wr_en_out SHALL be 0, and im_wr_addr_out and im_wr_data_out SHALL hold their last values.
REQ-026 cpu_rst_out SHALL be 1 in every state except DONE.
REQ-027 cpu_rst_out SHALL fall on the same edge that enters DONE.
REQ-028 load_done_out SHALL be 1 only in DONE; err_out SHALL be 1 only in ERR.
REQ-029 DONE and ERR SHALL be terminal; only reset leaves them.
REQ-030 rx_valid_in deasserting mid-image SHALL stall the loader in its current state with no timeout.
REQ-031 Minimum load time SHALL be 4N+3 cycles: 3 byte cycles plus 1 write cycle per instruction, plus 3 cycles for header and checksum.

Reset
REQ-032 On cus19_rst_in low, at any time and even mid-write, the loader SHALL immediately force:
- state HDR_HI, address 0, counter 0, XOR 0;
- im_wr_en_out 0, im_wr_addr_out 0, im_wr_data_out 0;
- cpu_rst_out 1, load_done_out 0, err_out 0, rx_ready_out 0.
REQ-033 rx_ready_out SHALL rise in the first cycle after reset deassertion.
REQ-034 A partially loaded image SHALL be abandoned on reset; memory contents already written are not cleared.

Structure
REQ-035 The state encoding and the constants HDR_BYTES=2 and INSTR_BYTES=3 SHALL live in the shared cus19 package.
REQ-036 The block SHALL be a single module with no sub-modules.
REQ-037 The loader SHALL sit upstream of cus19_top_module: its outputs drive the instruction-memory write port and the core reset.

Verification
REQ-038 N=1 stream 00 01 05 A3 7C DB SHALL produce one write of 19'h5A37C at address 0, then load_done_out=1 and cpu_rst_out=0.
REQ-039 The same stream with checksum DA SHALL produce the write at address 0, then err_out=1 with cpu_rst_out held at 1.
REQ-040 Header 00 00 SHALL produce err_out=1 two accepts later with no im_wr_en_out pulse; header 08 01 SHALL likewise produce err_out=1.
REQ-041 N=2048 with random data and a correct checksum SHALL produce 2048 writes at addresses 0..2047, each in order with matching data, and then DONE.
REQ-042 N=3 with rx_valid_in toggled randomly SHALL produce the same writes as back-to-back delivery, with rx_ready_out=0 during each write cycle.
REQ-043 cus19_rst_in asserted low after the second instruction's b1 SHALL force all outputs to reset values asynchronously; a fresh N=1 image afterwards SHALL load at address 0.
